// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default frame shape.
// Used by uart_tx_serializer/uart_tx_hold now and by the future receiver.
package uart_pkg;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_STOP_BITS = 1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Encodings stay fixed so legacy code and probes see the same values
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_hold.sv
// One-entry holding register in front of the UART shifter.
// Accepts on valid&&ready; the shifter empties it through i_clear when it loads a frame.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_clear,
  output logic                 o_full,
  output logic [DATA_BITS-1:0] o_data
);

  logic                 r_full;
  logic                 r_ready;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_accept;

  assign w_accept = i_valid && r_ready;

  // r_ready is kept as its own flop (always !r_full) so the port is a clean register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
    end else if (w_accept) begin
      r_data  <= i_data;
      r_full  <= 1'b1;
      r_ready <= 1'b0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: hold register + LSB-first shifter, one bit per baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned      CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bitcnt;
  logic                 r_stopcnt;
  logic                 r_tx;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_hold_full;
  logic [DATA_BITS-1:0] w_hold_data;
  logic                 w_reload;

  // A frame is loaded from hold either from IDLE or on the tick ending the last stop bit
  assign w_reload = baud_tick && w_hold_full &&
                    ((r_state == IDLE) || ((r_state == STOP) && (r_stopcnt == STOP_LAST)));

  uart_tx_hold #(
    .DATA_BITS(DATA_BITS)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (tx_data),
    .i_valid (tx_valid),
    .o_ready (tx_ready),
    .i_clear (w_reload),
    .o_full  (w_hold_full),
    .o_data  (w_hold_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_tx      <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (baud_tick) begin
      if (w_reload) begin
        r_shift  <= w_hold_data;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^w_hold_data;
`endif
        r_tx     <= START_BIT;
        r_state  <= START;
      end else begin
        case (r_state)
          IDLE: r_tx <= LINE_IDLE;
          START: begin
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= '0;
            r_state  <= DATA;
          end
          DATA: begin
            if (r_bitcnt == BIT_LAST) begin
              r_stopcnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
              r_tx      <= r_parity;
              r_state   <= PARITY;
`else
              r_tx      <= LINE_IDLE;
              r_state   <= STOP;
`endif
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          PARITY: begin
            r_tx      <= LINE_IDLE;
            r_stopcnt <= 1'b0;
            r_state   <= STOP;
          end
          STOP: begin
            if (r_stopcnt == STOP_LAST) begin
              r_tx    <= LINE_IDLE;
              r_state <= IDLE;
            end else begin
              r_stopcnt <= r_stopcnt + 1'b1;
            end
          end
          default: begin
            r_tx    <= LINE_IDLE;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != IDLE);

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART 8N1 transmitter. Sits directly downstream of the baud-rate divider and consumes its per-bit strobe.
- Accepts parallel bytes over a valid/ready handshake and buffers one byte in a holding register.
- Shifts each frame out LSB-first on a registered serial line. Every bit lasts exactly one `baud_tick` interval.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- baud_tick  input  1  one-clk-wide strobe, one per bit period, synchronous to clk; produced by the baud divider.
- tx_data  input  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  input  1  tx_data valid; once asserted, must be held stable until accepted.
- tx_ready  output  1  holding register empty; registered, equals !hold_full.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high while a frame is on the line (state != IDLE).

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n), used with clock clk.
- Reset values: tx=1, tx_ready=1, busy=0, state=IDLE, hold empty, bit counter 0.
- Reset mid-frame: line returns high immediately (async). The frame is aborted and the held byte is discarded.
- Handshake:
  - Accept occurs on a clk edge with tx_valid && tx_ready.
  - tx_data is copied to the hold register; tx_ready drops the next cycle.
  - tx_valid while tx_ready=0 is ignored; there is no combinational bypass.
- States: IDLE, START, DATA, [PARITY], STOP. All transitions occur only on clk edges where baud_tick=1.
  - IDLE: tx=1. On a tick with hold_full: load the shift register from hold, clear hold (tx_ready=1 next cycle), tx<=0, go to START. Ticks with hold empty are ignored.
  - START: on tick, tx<=shift[0], shift right, bitcnt<=0, go to DATA.
  - DATA: on tick, if bitcnt==DATA_BITS-1 go to PARITY (if compiled) else STOP, with tx<=parity or 1 respectively. Otherwise tx<=next bit and bitcnt++.
  - PARITY: on tick, tx<=1, go to STOP.
  - STOP: on tick, if fewer than STOP_BITS stop periods have elapsed, stay. On the tick ending the last stop bit: if hold_full, reload and go to START with tx<=0 (back-to-back, no extra idle bit); else go to IDLE.
- Latency: the start bit begins on the first baud_tick after the byte lands in hold, i.e. 1 to one-bit-period plus 1 clk after the handshake.
- Frame length: 1 + DATA_BITS + [1] + STOP_BITS tick intervals.
- Simultaneous reload and accept: hold clears on the reload edge and tx_ready is low that cycle, so there is no conflict. The new byte is accepted on a following cycle.
- baud_tick coinciding with a handshake in IDLE: the byte is not yet in hold, so it starts on the next tick.
- bitcnt width is $clog2(DATA_BITS). The shift register is DATA_BITS wide.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA. The bit is even parity, the XOR of all data bits of the frame, computed when the shift register is loaded. Frame grows by one bit.
- Undefined: no PARITY state; DATA goes directly to STOP. Port list is identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - line levels (LINE_IDLE=1, START_BIT=0);
  - default DATA_BITS/STOP_BITS constants, shared with the future receiver.
- One natural sub-module: uart_tx_hold, the one-entry holding register with valid/ready and a load/clear interface. The FSM and shifter stay in the top module.

Test Plan:
- 0x55, tick every 16 clk, no parity: tx line per tick interval = 0,1,0,1,0,1,0,1,0,1. busy is high for exactly 10 intervals, then tx stays 1.
- Back-to-back 0xA3 then 0x0F, second byte offered while the first shifts: second start bit begins on the tick ending the first stop bit. Line = 0,11000101,1,0,11110000,1.
- Reset asserted mid-DATA of 0xFF: tx=1, tx_ready=1, busy=0 immediately. After release, no residual bits appear for 20 ticks.
- tx_valid held with baud_tick stuck low: one byte accepted, tx_ready=0, tx stays 1, busy=0 indefinitely. The frame starts on the first tick.
- STOP_BITS=2, byte 0x00: line = 0,00000000,1,1. The next queued byte starts only after both stop intervals.
- UART_TX_PARITY_EN defined: 0x07 gives parity 1 and 0x03 gives parity 0, each inserted between bit 7 and the stop bit (11 intervals per frame).
